// File: rtl/teclado_senha.sv
// 4x4 matrix keypad scanner with debounce and password accumulator for the lock controller.
// Optional `TECLADO_ECO_EN adds eco_bcd, a masked entry-progress echo for the display.
module teclado_senha #(
  parameter int SCAN_TICKS = 1000,
  parameter int DEBOUNCE   = 50000,
  parameter int TIMEOUT    = 250000000,
  parameter int NDIG       = 12,
  parameter int MIN_DIG    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              teclado_en,
  input  logic [3:0]        col,
  output logic [3:0]        lin,
  output logic [NDIG*4-1:0] digitos_value,
  output logic              digitos_valid
`ifdef TECLADO_ECO_EN
  ,
  output logic [23:0]       eco_bcd
`endif
);

  localparam int SC_W  = $clog2(SCAN_TICKS > 2 ? SCAN_TICKS : 2);
  localparam int DB_W  = $clog2(DEBOUNCE > 2 ? DEBOUNCE : 2);
  localparam int TO_W  = $clog2(TIMEOUT > 2 ? TIMEOUT : 2);
  localparam int CNT_W = $clog2(NDIG + 1);
  // col reaches col_s two cycles after a row change; earlier samples belong to the old row
  localparam int SETTLE = (SCAN_TICKS > 2) ? 2 : 0;

  localparam logic [SC_W-1:0]   SC_MAX  = SC_W'(SCAN_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE - 1);
  localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0]   SC_SET  = SC_W'(SETTLE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0]  CNT_MIN = CNT_W'(MIN_DIG);
  localparam logic [NDIG*4-1:0] ALL_F   = {NDIG{4'hF}};
  localparam logic [NDIG*4-1:0] ALL_E   = {NDIG{4'hE}};

  typedef enum logic [2:0] {IDLE, SCAN, DEB_PRESS, HOLD, DEB_RELEASE} state_t;

  state_t            state, state_n;
  logic [1:0]        row, row_n, kcol, kcol_n;
  logic [SC_W-1:0]   scan_cnt, scan_cnt_n;
  logic [DB_W-1:0]   deb_cnt, deb_cnt_n;
  logic [3:0]        col_m, col_s;
  logic [1:0]        low_idx;
  logic              key_fire;
  logic [3:0]        code;
  logic [NDIG*4-1:0] pkg;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              digit_ok, is_star, is_hash, tmo_fire;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  always_comb begin
    if (!col_s[0])      low_idx = 2'd0;
    else if (!col_s[1]) low_idx = 2'd1;
    else if (!col_s[2]) low_idx = 2'd2;
    else                low_idx = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row      <= 2'd0;
      kcol     <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      kcol     <= kcol_n;
      scan_cnt <= scan_cnt_n;
      deb_cnt  <= deb_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    row_n      = row;
    kcol_n     = kcol;
    scan_cnt_n = scan_cnt;
    deb_cnt_n  = deb_cnt;
    key_fire   = 1'b0;
    if (!teclado_en) begin
      state_n    = IDLE;
      row_n      = 2'd0;
      scan_cnt_n = '0;
      deb_cnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n    = SCAN;
          row_n      = 2'd0;
          scan_cnt_n = '0;
        end
        SCAN: begin
          if (scan_cnt >= SC_SET && col_s != 4'hF) begin
            state_n   = DEB_PRESS;
            kcol_n    = low_idx;
            deb_cnt_n = '0;
          end else if (scan_cnt == SC_MAX) begin
            scan_cnt_n = '0;
            row_n      = row + 2'd1;
          end else begin
            scan_cnt_n = scan_cnt + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (col_s[kcol]) begin
            state_n    = SCAN;
            scan_cnt_n = '0;
          end else if (deb_cnt == DB_MAX) begin
            key_fire = 1'b1;
            state_n  = HOLD;
          end else begin
            deb_cnt_n = deb_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (&col_s) begin
            state_n   = DEB_RELEASE;
            deb_cnt_n = '0;
          end
        end
        DEB_RELEASE: begin
          if (!(&col_s)) begin
            state_n = HOLD;
          end else if (deb_cnt == DB_MAX) begin
            state_n    = SCAN;
            scan_cnt_n = '0;
          end else begin
            deb_cnt_n = deb_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb lin = (state == IDLE) ? 4'hF : ~(4'b0001 << row);

  assign code     = key_code(row, kcol);
  assign digit_ok = key_fire && (code <= 4'd9) && (cnt < CNT_MAX);
  assign is_star  = key_fire && (code == 4'hE);
  assign is_hash  = key_fire && (code == 4'hF) && (cnt != '0);
  // any key event, even an ignored A-D, pre-empts a timeout landing on the same cycle
  assign tmo_fire = !key_fire && (cnt != '0) && (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkg           <= ALL_F;
      cnt           <= '0;
      to_cnt        <= '0;
      digitos_value <= ALL_F;
      digitos_valid <= 1'b0;
    end else begin
      digitos_valid <= 1'b0;
      if (!teclado_en || is_star) begin
        pkg    <= ALL_F;
        cnt    <= '0;
        to_cnt <= '0;
      end else if (digit_ok) begin
        pkg    <= {pkg[NDIG*4-5:0], code};
        cnt    <= cnt + 1'b1;
        to_cnt <= '0;
      end else if (is_hash || tmo_fire) begin
        digitos_value <= (is_hash && cnt >= CNT_MIN) ? pkg : ALL_E;
        digitos_valid <= 1'b1;
        pkg           <= ALL_F;
        cnt           <= '0;
        to_cnt        <= '0;
      end else if (!key_fire && cnt != '0) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

`ifdef TECLADO_ECO_EN
  function automatic logic [23:0] eco_of(input logic [CNT_W-1:0] c);
    logic [23:0] e;
    e = 24'hBBBBBB;
    for (int i = 0; i < 6; i++) e[i*4 +: 4] = (i < int'(c)) ? 4'hA : 4'hB;
    return e;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          eco_bcd <= 24'hBBBBBB;
    else if (!teclado_en || is_star || is_hash || tmo_fire) eco_bcd <= 24'hBBBBBB;
    else if (digit_ok)                                eco_bcd <= eco_of(cnt + 1'b1);
  end
`endif

endmodule
